// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder.
//   state_t          : access FSM states
//   IO_ADDR_DEFAULT  : default memory-mapped I/O word address
//   WORD_W           : bus and RAM word width
package mem_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_WR_WAIT,
    ST_WR_DONE
  } state_t;

  localparam int          WORD_W          = 16;
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, asynchronous read. Contents are
// never reset.
//   clk   : write clock
//   we    : write enable, sampled on the rising edge
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : combinational read data at addr
module mem_array #(
  parameter int DEPTH_W = 10,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the SLC-3 memory bus. Services held Mem_OE /
// Mem_WE strobes against an internal RAM with a fixed wait-state count and
// maps IO_ADDR to the switches (read) and the hex display register (write).
//   Clk, Reset     : clock, asynchronous active-high reset
//   Mem_OE, Mem_WE : read / write strobes, held for the whole access
//   ADDR           : word address from MAR
//   Data_from_CPU  : write data from MDR
//   Switches       : value returned for a read of IO_ADDR
//   Data_to_CPU    : registered read data
//   HEX_Data       : registered value last written to IO_ADDR
//   Ready          : read data valid / write committed
//   Err            : one-cycle pulse per cycle with both strobes high in IDLE
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH_W = 10,
  parameter int          RD_LAT  = 2,
  parameter int          WR_LAT  = 2,
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic [15:0] HEX_Data,
  output logic        Ready,
  output logic        Err
);

  state_t              state;
  logic [2:0]          cnt;
  logic [15:0]         addr_q;
  logic [15:0]         data_q;
  logic                is_io;
  logic                mem_we;
  logic [WORD_W-1:0]   mem_rdata;

  assign is_io = (addr_q == IO_ADDR);

  // RAM commit happens on the same edge the FSM leaves WR_WAIT, so a write
  // is performed exactly once per access and never for the I/O address.
  assign mem_we = (state == ST_WR_WAIT) && Mem_WE && (cnt == 3'd1) && !is_io;

  mem_array #(
    .DEPTH_W (DEPTH_W),
    .DATA_W  (WORD_W)
  ) u_mem (
    .clk   (Clk),
    .we    (mem_we),
    .addr  (addr_q[DEPTH_W-1:0]),
    .wdata (data_q),
    .rdata (mem_rdata)
  );

  // Address/data capture: only in IDLE at the start of a valid access, so
  // later changes on the bus are ignored for the rest of the access.
  always_ff @(posedge Clk) begin
    if ((state == ST_IDLE) && (Mem_OE ^ Mem_WE)) begin
      addr_q <= ADDR;
      data_q <= Data_from_CPU;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cnt         <= 3'd0;
      Data_to_CPU <= 16'h0000;
      HEX_Data    <= 16'h0000;
      Ready       <= 1'b0;
      Err         <= 1'b0;
    end else begin
      Err <= 1'b0;
      case (state)
        ST_IDLE: begin
          Ready <= 1'b0;
          if (Mem_OE && Mem_WE) begin
            Err <= 1'b1;
          end else if (Mem_OE) begin
            cnt   <= 3'(RD_LAT - 1);
            state <= ST_RD_WAIT;
          end else if (Mem_WE) begin
            cnt   <= 3'(WR_LAT - 1);
            state <= ST_WR_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (!Mem_OE) begin
            state <= ST_IDLE;
          end else if (cnt == 3'd1) begin
            Data_to_CPU <= is_io ? Switches : mem_rdata;
            Ready       <= 1'b1;
            state       <= ST_RD_HOLD;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_RD_HOLD: begin
          if (!Mem_OE) begin
            Ready <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_WR_WAIT: begin
          if (!Mem_WE) begin
            state <= ST_IDLE;
          end else if (cnt == 3'd1) begin
            if (is_io) begin
              HEX_Data <= data_q;
            end
            Ready <= 1'b1;
            state <= ST_WR_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_WR_DONE: begin
          if (!Mem_WE) begin
            Ready <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          Ready <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default parameters
// (DEPTH_W=10, RD_LAT=2, WR_LAT=2, IO_ADDR=16'hFFFF).
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic [15:0] HEX_Data;
  logic        Ready;
  logic        Err;

  int checks = 0;
  int errors = 0;

  logic [15:0] dout_log [8];
  logic [15:0] hex_log  [8];
  logic        rdy_log  [8];

  mem_responder dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Switches      (Switches),
    .Data_to_CPU   (Data_to_CPU),
    .HEX_Data      (HEX_Data),
    .Ready         (Ready),
    .Err           (Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Holds one strobe for n cycles (cycle 0 is the first strobe cycle), then
  // spends one cycle with both strobes low. ADDR switches to a_late after
  // the capture cycle. Outputs are logged mid-cycle.
  task automatic access(input logic rd, input logic [15:0] a, input logic [15:0] a_late,
                        input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      start_cycle();
      Mem_OE        = rd;
      Mem_WE        = !rd;
      ADDR          = (i == 0) ? a : a_late;
      Data_from_CPU = d;
      #3;
      rdy_log[i]  = Ready;
      dout_log[i] = Data_to_CPU;
      hex_log[i]  = HEX_Data;
    end
    start_cycle();
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
    #3;
  endtask

  initial begin
    Reset         = 1'b1;
    Mem_OE        = 1'b0;
    Mem_WE        = 1'b0;
    ADDR          = 16'h0000;
    Data_from_CPU = 16'h0000;
    Switches      = 16'h0000;

    // Reset values before any clock edge
    #2;
    check("rst_dout",  Data_to_CPU, 16'h0000);
    check("rst_hex",   HEX_Data,    16'h0000);
    check("rst_ready", 16'(Ready),  16'h0000);
    check("rst_err",   16'(Err),    16'h0000);
    @(posedge Clk);
    start_cycle();
    Reset = 1'b0;

    // Write 0x1234 to 0x0010, then read it back
    access(1'b0, 16'h0010, 16'h0010, 16'h1234, 3);
    check("wr_rdy_c0", 16'(rdy_log[0]), 16'h0000);
    check("wr_rdy_c1", 16'(rdy_log[1]), 16'h0000);
    check("wr_rdy_c2", 16'(rdy_log[2]), 16'h0001);
    access(1'b1, 16'h0010, 16'h0010, 16'h0000, 3);
    check("rd_rdy_c1",  16'(rdy_log[1]), 16'h0000);
    check("rd_rdy_c2",  16'(rdy_log[2]), 16'h0001);
    check("rd_dout_c2", dout_log[2],     16'h1234);

    // Switches read at the I/O address
    Switches = 16'hBEEF;
    access(1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 3);
    check("io_rd_dout_c1", dout_log[1], 16'h1234);
    check("io_rd_dout_c2", dout_log[2], 16'hBEEF);

    // I/O write must not alias onto RAM word 0x03FF
    access(1'b0, 16'h03FF, 16'h03FF, 16'h7777, 3);
    access(1'b0, 16'hFFFF, 16'hFFFF, 16'h00A5, 3);
    check("io_wr_hex_c1", hex_log[1], 16'h0000);
    check("io_wr_hex_c2", hex_log[2], 16'h00A5);
    check("io_wr_hex",    HEX_Data,   16'h00A5);
    access(1'b1, 16'h03FF, 16'h03FF, 16'h0000, 3);
    check("rd_3ff", dout_log[2], 16'h7777);

    // One-cycle OE: aborted read
    access(1'b1, 16'h0010, 16'h0010, 16'h0000, 1);
    check("abort_rd_rdy",  16'(Ready), 16'h0000);
    check("abort_rd_dout", Data_to_CPU, 16'h7777);
    start_cycle();
    #3;
    check("abort_rd_rdy_idle", 16'(Ready), 16'h0000);
    check("abort_rd_dout_idle", Data_to_CPU, 16'h7777);

    // One-cycle WE: aborted write leaves old value
    access(1'b0, 16'h0020, 16'h0020, 16'h1111, 3);
    access(1'b0, 16'h0020, 16'h0020, 16'hDEAD, 1);
    access(1'b1, 16'h0020, 16'h0020, 16'h0000, 3);
    check("abort_wr_rd", dout_log[2], 16'h1111);

    // OE and WE together in IDLE for two cycles
    start_cycle();
    Mem_OE = 1'b1; Mem_WE = 1'b1; ADDR = 16'h0020; Data_from_CPU = 16'hBAD0;
    #3;
    check("err_c0", 16'(Err), 16'h0000);
    start_cycle();
    #3;
    check("err_c1", 16'(Err), 16'h0001);
    check("err_c1_rdy", 16'(Ready), 16'h0000);
    start_cycle();
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    #3;
    check("err_c2", 16'(Err), 16'h0001);
    start_cycle();
    #3;
    check("err_c3", 16'(Err), 16'h0000);
    access(1'b1, 16'h0020, 16'h0020, 16'h0000, 3);
    check("err_rdy_c2", 16'(rdy_log[2]), 16'h0001);
    check("err_no_wr",  dout_log[2],     16'h1111);

    // Reset in the middle of RD_WAIT
    access(1'b1, 16'h0010, 16'h0010, 16'h0000, 3);
    check("pre_rst_dout", dout_log[2], 16'h1234);
    start_cycle();
    Mem_OE = 1'b1; ADDR = 16'h0020;
    start_cycle();
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_dout",  Data_to_CPU, 16'h0000);
    check("mid_rst_hex",   HEX_Data,    16'h0000);
    check("mid_rst_ready", 16'(Ready),  16'h0000);
    check("mid_rst_err",   16'(Err),    16'h0000);
    Mem_OE = 1'b0;
    start_cycle();
    Reset = 1'b0;
    access(1'b1, 16'h0010, 16'h0010, 16'h0000, 3);
    check("post_rst_rd", dout_log[2], 16'h1234);

    // Aliasing and ADDR change after capture
    access(1'b0, 16'h0001, 16'h0001, 16'h2222, 3);
    access(1'b0, 16'h0400, 16'h0001, 16'h5555, 3);
    check("alias_wr_rdy", 16'(rdy_log[2]), 16'h0001);
    access(1'b1, 16'h0000, 16'h0000, 16'h0000, 3);
    check("alias_rd_0000", dout_log[2], 16'h5555);
    access(1'b1, 16'h0001, 16'h0001, 16'h0000, 3);
    check("alias_rd_0001", dout_log[2], 16'h2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the SLC-3 datapath's memory bus. Services the control unit's active-high Mem_OE and Mem_WE strobes against an internal word-addressed RAM, with a fixed, parameterised wait-state count. Maps one I/O address to board switches (read) and a hex-display register (write). Sits between MAR/MDR and the on-chip memory, so the control unit's multi-cycle read and write states always see data or commit on time.

## Interface
Parameters:
- DEPTH_W, 10: RAM address width; depth is 2^DEPTH_W words of 16 bits.
- RD_LAT, 2: read latency in cycles from the first OE cycle; legal range 2..7.
- WR_LAT, 2: cycles from the first WE cycle to commit; legal range 2..7.
- IO_ADDR, 16'hFFFF: memory-mapped I/O address.

Ports:
- Clk, in, 1: the only clock; all state changes on its rising edge.
- Reset, in, 1: asynchronous, active-high.
- Mem_OE, in, 1: read strobe, held for the whole access.
- Mem_WE, in, 1: write strobe, held for the whole access.
- ADDR, in, 16: word address from MAR.
- Data_from_CPU, in, 16: write data from MDR.
- Switches, in, 16: value returned for a read of IO_ADDR.
- Data_to_CPU, out, 16: registered read data to MDR.
- HEX_Data, out, 16: registered value last written to IO_ADDR.
- Ready, out, 1: data valid (read) or write committed.
- Err, out, 1: one-cycle pulse when OE and WE are both seen high in IDLE.

## Operation
- FSM states: IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_DONE. Down-counter cnt is 3 bits.
- IDLE with OE=1 and WE=0:
  - Latch ADDR into addr_q, set cnt to RD_LAT-1, go to RD_WAIT.
- RD_WAIT:
  - OE=0: abort to IDLE; Data_to_CPU unchanged.
  - cnt==1: register Data_to_CPU. Source is Switches if addr_q==IO_ADDR, otherwise mem[addr_q[DEPTH_W-1:0]]. Go to RD_HOLD.
  - Otherwise decrement cnt.
- RD_HOLD: Ready=1. Stay while OE=1; go to IDLE when OE=0. Data_to_CPU holds until the next completed read.
- IDLE with WE=1 and OE=0:
  - Latch ADDR and Data_from_CPU, set cnt to WR_LAT-1, go to WR_WAIT.
- WR_WAIT:
  - WE=0: abort to IDLE; nothing written.
  - cnt==1: commit the latched data to HEX_Data if addr_q==IO_ADDR, otherwise to RAM. Go to WR_DONE.
  - Otherwise decrement cnt.
- WR_DONE: Ready=1. Stay while WE=1, with exactly one commit per access; go to IDLE when WE=0.
- IDLE with OE=1 and WE=1: no access, stay in IDLE, pulse Err on the next cycle. Err repeats on each conflicting cycle.
- ADDR and Data_from_CPU changes after the capture cycle are ignored.
- Non-I/O addresses alias modulo 2^DEPTH_W. A write to IO_ADDR never touches RAM.
- In RD_WAIT/RD_HOLD, WE is ignored. In WR_WAIT/WR_DONE, OE is ignored.

## Timing
- Reset (asynchronous):
  - State goes to IDLE, cnt=0.
  - Data_to_CPU, HEX_Data, Ready and Err go to 0 immediately, without a clock edge.
  - RAM contents are not reset. A reset during any access discards it; no partial write.
- Read: with the first OE cycle numbered 0, Data_to_CPU is valid and Ready=1 from cycle RD_LAT.
  - Default RD_LAT=2: valid in cycle 2, so an MDR load at the end of the third OE cycle captures correct data.
- Write: RAM or HEX_Data updates on the edge ending cycle WR_LAT-1. Ready=1 from cycle WR_LAT.
- Back-to-back: the cycle after a strobe drops is spent in IDLE. A new strobe in that IDLE cycle is captured there, so there is no extra turnaround cycle.
- Ready and Err are registered outputs.

## Structure
- Package mem_resp_pkg holds the state enum and the IO_ADDR default constant.
- Sub-module mem_array: single-port RAM with 2^DEPTH_W×16 words, synchronous write enable and asynchronous read.
- mem_responder contains the FSM, counter, address/data capture registers, I/O decode, and the Data_to_CPU/HEX_Data registers.

## Test plan
- Write 0x1234 to 0x0010 with WE held 3 cycles, then read 0x0010 with OE held 3 cycles -> Ready=1 in cycle 2 of each access; Data_to_CPU=0x1234 in read cycle 2.
- Switches=0xBEEF, read 0xFFFF -> Data_to_CPU=0xBEEF in cycle 2. Write 0x00A5 to 0xFFFF -> HEX_Data=0x00A5, and a later read of 0x03FF is unchanged.
- OE high for 1 cycle only -> Data_to_CPU unchanged, Ready stays 0. WE high for 1 cycle to 0x0020 -> a subsequent read of 0x0020 returns the old value.
- OE and WE both high in IDLE for 2 cycles -> Err=1 for 2 cycles, state stays IDLE, no RAM change.
- Reset asserted mid-RD_WAIT -> all outputs 0 before the next edge. After release, a read of 0x0010 still returns 0x1234.
- DEPTH_W=10: write 0x5555 to 0x0400, with ADDR changed to 0x0001 during WR_WAIT -> a read of 0x0000 returns 0x5555, and 0x0001 is unchanged.
